// File: rtl/vec_seq_ctrl.sv
// Sequential vector add/subtract over an NREG x VLEN register file, one element per cycle.
// Build option: define VEC_SEQ_SAT_EN for unsigned saturating arithmetic (default is modulo).
module vec_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int VLEN   = 8,
    parameter int NREG   = 4,
    localparam int IW    = $clog2(VLEN),
    localparam int RW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [RW-1:0]     cmd_src1,
    input  logic [RW-1:0]     cmd_src2,
    input  logic [RW-1:0]     cmd_dst,
    input  logic [IW-1:0]     cmd_len,
    input  logic              wr_en,
    input  logic [RW-1:0]     wr_reg,
    input  logic [IW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [RW-1:0]     rd_reg,
    input  logic [IW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, and command fields are sampled only on that edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    logic [IW-1:0]       idx;
    logic                op_q;
    logic [RW-1:0]       src1_q;
    logic [RW-1:0]       src2_q;
    logic [RW-1:0]       dst_q;
    logic [IW-1:0]       len_q;
    logic [DATA_W-1:0]   v [NREG][VLEN];

    logic [DATA_W-1:0]   opa;
    logic [DATA_W-1:0]   opb;
    logic [DATA_W-1:0]   alu_res;

`ifdef VEC_SEQ_SAT_EN
    logic [DATA_W:0]     wide_sum;

    always_comb begin
        opa      = v[src1_q][idx];
        opb      = v[src2_q][idx];
        wide_sum = {1'b0, opa} + {1'b0, opb};
        alu_res  = '0;
        if (op_q) begin
            alu_res = (opa < opb) ? '0 : (opa - opb);
        end else begin
            alu_res = wide_sum[DATA_W] ? '1 : wide_sum[DATA_W-1:0];
        end
    end
`else
    always_comb begin
        opa     = v[src1_q][idx];
        opb     = v[src2_q][idx];
        alu_res = op_q ? (opa - opb) : (opa + opb);
    end
`endif

    // Host writes and element writes never coincide: the former only land in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            op_q   <= 1'b0;
            src1_q <= '0;
            src2_q <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            for (int r = 0; r < NREG; r++) begin
                for (int i = 0; i < VLEN; i++) begin
                    v[r][i] <= '0;
                end
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_en) begin
                        v[wr_reg][wr_idx] <= wr_data;
                    end
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        src1_q <= cmd_src1;
                        src2_q <= cmd_src2;
                        dst_q  <= cmd_dst;
                        len_q  <= cmd_len;
                        idx    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    v[dst_q][idx] <= alu_res;
                    if (idx == len_q) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;
    assign rd_data   = v[rd_reg][rd_idx];

endmodule

// File: tb/tb_vec_seq_ctrl.sv
// Directed self-checking bench for vec_seq_ctrl; expected values hand-computed,
// switched on VEC_SEQ_SAT_EN where the arithmetic mode changes them.
module tb_vec_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [1:0] cmd_src1;
    logic [1:0] cmd_src2;
    logic [1:0] cmd_dst;
    logic [2:0] cmd_len;
    logic       wr_en;
    logic [1:0] wr_reg;
    logic [2:0] wr_idx;
    logic [7:0] wr_data;
    logic [1:0] rd_reg;
    logic [2:0] rd_idx;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    vec_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_reg(rd_reg), .rd_idx(rd_idx), .rd_data(rd_data),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic host_wr(input logic [1:0] r, input logic [2:0] i, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_reg = r; wr_idx = i; wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic read_el(input logic [1:0] r, input logic [2:0] i, output logic [7:0] d);
        rd_reg = r; rd_idx = i;
        #1 d = rd_data;
    endtask

    // Pops exp_q against V[r][0..n-1].
    task automatic check_vec(input string tag, input logic [1:0] r, input int n);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            read_el(r, i[2:0], d);
            check($sformatf("%s[%0d]", tag, i), {24'd0, d}, {24'd0, exp_q.pop_front()});
        end
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        @(negedge clk);
        while (!done && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic run_cmd(input string tag, input logic op, input logic [1:0] s1,
                           input logic [1:0] s2, input logic [1:0] d, input logic [2:0] len,
                           input bit with_wr, input logic [1:0] wr_r, input logic [2:0] wr_i,
                           input logic [7:0] wr_d);
        int cyc;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_src1 = s1; cmd_src2 = s2; cmd_dst = d; cmd_len = len;
        if (with_wr) begin
            wr_en = 1'b1; wr_reg = wr_r; wr_idx = wr_i; wr_data = wr_d;
        end
        check({tag, "_ready_pre"}, {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; wr_en = 1'b0;
        cmd_op   = 1'($urandom_range(0, 1));
        cmd_src1 = 2'($urandom_range(0, 3));
        cmd_src2 = 2'($urandom_range(0, 3));
        cmd_dst  = 2'($urandom_range(0, 3));
        cmd_len  = 3'($urandom_range(0, 7));
        wait_done(tag, cyc);
        check({tag, "_run_cycles"}, cyc, {29'd0, len} + 32'd1);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        check({tag, "_ready_post"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] d;
        int cyc;
        int bad;
        bit done_seen;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_src1 = '0; cmd_src2 = '0;
        cmd_dst = '0; cmd_len = '0; wr_en = 1'b0; wr_reg = '0; wr_idx = '0; wr_data = '0;
        rd_reg = '0; rd_idx = '0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rd", {24'd0, rd_data}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Full-length add
        for (int i = 0; i < 8; i++) host_wr(2'd0, i[2:0], 8'(i + 1));
        for (int i = 0; i < 8; i++) host_wr(2'd1, i[2:0], 8'(10 * (i + 1)));
        run_cmd("add8", 1'b0, 2'd0, 2'd1, 2'd2, 3'd7, 1'b0, 2'd0, 3'd0, 8'd0);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(11 * (i + 1)));
        check_vec("add8_v2", 2'd2, 8);

        // Overflow / underflow boundaries and untouched tail
        host_wr(2'd0, 3'd0, 8'd200);
        host_wr(2'd1, 3'd0, 8'd100);
        run_cmd("ovf", 1'b0, 2'd0, 2'd1, 2'd2, 3'd0, 1'b0, 2'd0, 3'd0, 8'd0);
`ifdef VEC_SEQ_SAT_EN
        exp_q.push_back(8'd255);
`else
        exp_q.push_back(8'd44);
`endif
        exp_q.push_back(8'd22);
        check_vec("ovf_v2", 2'd2, 2);
        host_wr(2'd0, 3'd1, 8'd5);
        host_wr(2'd1, 3'd1, 8'd10);
        run_cmd("unf", 1'b1, 2'd0, 2'd1, 2'd3, 3'd1, 1'b0, 2'd0, 3'd0, 8'd0);
        exp_q.push_back(8'd100);
`ifdef VEC_SEQ_SAT_EN
        exp_q.push_back(8'd0);
`else
        exp_q.push_back(8'd251);
`endif
        exp_q.push_back(8'd0);
        check_vec("unf_v3", 2'd3, 3);

        // In-place subtract over first four elements
        for (int i = 0; i < 8; i++) host_wr(2'd0, i[2:0], 8'd3);
        run_cmd("inplace", 1'b1, 2'd0, 2'd0, 2'd0, 3'd3, 1'b0, 2'd0, 3'd0, 8'd0);
        for (int i = 0; i < 8; i++) exp_q.push_back((i < 4) ? 8'd0 : 8'd3);
        check_vec("inplace_v0", 2'd0, 8);

        // Write and second command during RUN
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_src1 = 2'd0; cmd_src2 = 2'd1; cmd_dst = 2'd2; cmd_len = 3'd7;
        @(posedge clk);
        #1;
        cmd_op = 1'b1; cmd_src1 = 2'd1; cmd_src2 = 2'd0; cmd_dst = 2'd3; cmd_len = 3'd0;
        wr_en = 1'b1; wr_reg = 2'd1; wr_idx = 3'd0; wr_data = 8'd99;
        @(posedge clk);
        #1 wr_en = 1'b0;
        bad = 0; cyc = 0;
        @(negedge clk);
        while (!done && cyc < 20) begin
            if (cmd_ready) bad++;
            cyc++;
            @(negedge clk);
        end
        check("run_done", {31'd0, done}, 32'd1);
        check("ready_low_in_run", bad, 0);
        check("ready_low_in_done", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("ready_after_done", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("second_accepted", {31'd0, busy}, 32'd1);
        wait_done("second", cyc);
        @(negedge clk);
        read_el(2'd1, 3'd0, d);
        check("wr_in_run_dropped", {24'd0, d}, 32'd100);
        read_el(2'd3, 3'd0, d);
        check("second_v3", {24'd0, d}, 32'd100);
        exp_q = '{8'd100, 8'd10, 8'd30, 8'd40, 8'd53, 8'd63, 8'd73, 8'd83};
        check_vec("first_v2", 2'd2, 8);

        // Host write in the accept cycle feeds the first element
        run_cmd("wr_accept", 1'b0, 2'd0, 2'd0, 2'd3, 3'd0, 1'b1, 2'd0, 3'd0, 8'd60);
        read_el(2'd3, 3'd0, d);
        check("wr_accept_v3", {24'd0, d}, 32'd120);

        // Reset in the third RUN cycle
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_src1 = 2'd0; cmd_src2 = 2'd1; cmd_dst = 2'd2; cmd_len = 3'd7;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        cmd_valid = 1'b1; wr_en = 1'b1; wr_reg = 2'd1; wr_idx = 3'd2; wr_data = 8'd77;
        #1;
        check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; wr_en = 1'b0;
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("no_done_after_rst", {31'd0, done_seen}, 32'd0);
        check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);
        bad = 0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) begin
                read_el(r[1:0], i[2:0], d);
                if (d != 8'd0) bad++;
            end
        end
        check("v_cleared_by_rst", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
